// File: rtl/pwm_deadtime_gen.sv
// One inverter leg: compares the triangle carrier against a shadowed duty value and
// drives a complementary high/low gate pair with programmable dead time, enable and fault trip.
module pwm_deadtime_gen #(
  parameter int unsigned DEAD_CYCLES    = 40,
  parameter bit          UPDATE_AT_PEAK = 1'b0
) (
  input  logic        clk_20M,
  input  logic        reset,
  input  logic [15:0] carrier,
  input  logic        carrier_dir,
  input  logic [15:0] duty_in,
  input  logic        duty_wr,
  input  logic        enable,
  input  logic        fault_in,
  input  logic        trip_clr,
  output logic        pwm_h,
  output logic        pwm_l,
  output logic        trip,
  output logic [15:0] cmp_active
);

  typedef enum logic [2:0] {
    S_OFF,
    S_DEAD_TO_H,
    S_DEAD_TO_L,
    S_H_ON,
    S_L_ON
  } state_t;

  localparam logic [15:0] DEAD_LOAD = 16'(DEAD_CYCLES);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] shadow;
  logic        dir_q;
  logic        raw_q;
  logic        load_evt;

  // A rising carrier_dir marks the peak; the valley is simply carrier == 0.
  assign load_evt = (carrier == 16'd0) || (UPDATE_AT_PEAK && carrier_dir && !dir_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; that is what makes a same-cycle duty_wr and load event hand
  // the old shadow to cmp_active.
  always_ff @(posedge clk_20M or posedge reset) begin
    if (reset) begin
      shadow     <= '0;
      cmp_active <= '0;
      dir_q      <= 1'b0;
      raw_q      <= 1'b0;
      trip       <= 1'b0;
    end else begin
      if (duty_wr)  shadow     <= duty_in;
      if (load_evt) cmp_active <= shadow;
      dir_q <= carrier_dir;
      raw_q <= (carrier < cmp_active);
      if (fault_in)      trip <= 1'b1;
      else if (trip_clr) trip <= 1'b0;
    end
  end

  // Gates are registered from the next state so they move on the same edge as the FSM.
  always_ff @(posedge clk_20M or posedge reset) begin
    if (reset) begin
      state <= S_OFF;
      cnt   <= '0;
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pwm_h <= (state_nxt == S_H_ON);
      pwm_l <= (state_nxt == S_L_ON);
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (fault_in || !enable) begin
      state_nxt = S_OFF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_OFF: begin
          if (!trip) begin
            state_nxt = raw_q ? S_DEAD_TO_H : S_DEAD_TO_L;
            cnt_nxt   = DEAD_LOAD;
          end
        end
        S_DEAD_TO_H: begin
          if (!raw_q) begin
            state_nxt = S_DEAD_TO_L;
            cnt_nxt   = DEAD_LOAD;
          end else begin
            cnt_nxt = cnt - 16'd1;
            if (cnt <= 16'd1) state_nxt = S_H_ON;
          end
        end
        S_DEAD_TO_L: begin
          if (raw_q) begin
            state_nxt = S_DEAD_TO_H;
            cnt_nxt   = DEAD_LOAD;
          end else begin
            cnt_nxt = cnt - 16'd1;
            if (cnt <= 16'd1) state_nxt = S_L_ON;
          end
        end
        S_H_ON: begin
          if (!raw_q) begin
            state_nxt = S_DEAD_TO_L;
            cnt_nxt   = DEAD_LOAD;
          end
        end
        S_L_ON: begin
          if (raw_q) begin
            state_nxt = S_DEAD_TO_H;
            cnt_nxt   = DEAD_LOAD;
          end
        end
        default: begin
          state_nxt = S_OFF;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen: valley-update and peak-update instances share one
// triangle carrier (0..1000..0); expected timings are hand-derived cycle counts.
module tb_pwm_deadtime_gen;

  localparam int PEAK = 1000;

  logic        clk_20M;
  logic        reset;
  logic [15:0] carrier;
  logic        carrier_dir;
  logic [15:0] duty_in;
  logic        duty_wr;
  logic        enable;
  logic        fault_in;
  logic        trip_clr;
  logic        pwm_h, pwm_l, trip;
  logic [15:0] cmp_active;
  logic        pk_pwm_h, pk_pwm_l, pk_trip;
  logic [15:0] pk_cmp;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int overlap = 0;
  bit tri_run = 1'b0;

  pwm_deadtime_gen #(.DEAD_CYCLES(40), .UPDATE_AT_PEAK(1'b0)) u_dut (
    .clk_20M(clk_20M), .reset(reset), .carrier(carrier), .carrier_dir(carrier_dir),
    .duty_in(duty_in), .duty_wr(duty_wr), .enable(enable), .fault_in(fault_in),
    .trip_clr(trip_clr), .pwm_h(pwm_h), .pwm_l(pwm_l), .trip(trip), .cmp_active(cmp_active)
  );

  pwm_deadtime_gen #(.DEAD_CYCLES(40), .UPDATE_AT_PEAK(1'b1)) u_peak (
    .clk_20M(clk_20M), .reset(reset), .carrier(carrier), .carrier_dir(carrier_dir),
    .duty_in(duty_in), .duty_wr(duty_wr), .enable(enable), .fault_in(fault_in),
    .trip_clr(trip_clr), .pwm_h(pk_pwm_h), .pwm_l(pk_pwm_l), .trip(pk_trip), .cmp_active(pk_cmp)
  );

  initial begin
    clk_20M = 1'b0;
    forever #25 clk_20M = ~clk_20M;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1 ns after the edge, then advance the carrier model.
  task automatic tick();
    @(posedge clk_20M);
    #1;
    cyc++;
    if (pwm_h && pwm_l)       overlap++;
    if (pk_pwm_h && pk_pwm_l) overlap++;
    if (tri_run) begin
      if (!carrier_dir) begin
        if (carrier == 16'(PEAK - 1)) begin
          carrier     = 16'(PEAK);
          carrier_dir = 1'b1;
        end else carrier = carrier + 16'd1;
      end else begin
        if (carrier == 16'd1) begin
          carrier     = 16'd0;
          carrier_dir = 1'b0;
        end else carrier = carrier - 16'd1;
      end
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    int base, l0, g0, r0;
    int sat_bad, glitch_bad;
    reset = 1'b1; carrier = '0; carrier_dir = 1'b0; duty_in = '0; duty_wr = 1'b0;
    enable = 1'b0; fault_in = 1'b0; trip_clr = 1'b0;
    sat_bad = 0; glitch_bad = 0;

    // Reset state
    tick(); tick();
    check("rst_pwm_h", 32'(pwm_h), 0);
    check("rst_pwm_l", 32'(pwm_l), 0);
    check("rst_trip", 32'(trip), 0);
    check("rst_cmp", 32'(cmp_active), 0);

    // First enable with cmp_active=0: full dead time, then low side on
    reset = 1'b0; enable = 1'b1; base = cyc;
    run_to(base + 40);
    check("en_dead_l", 32'(pwm_l), 0);
    run_to(base + 41);
    check("en_l_on", 32'(pwm_l), 1);
    check("en_h_off", 32'(pwm_h), 0);

    // Saturation low for a full period; duty_wr=400 coincides with the peak event
    tri_run = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin duty_in = 16'd400; duty_wr = 1'b1; end
      tick();
      duty_wr = 1'b0;
      if (pwm_l !== 1'b1 || pwm_h !== 1'b0 || pk_pwm_l !== 1'b1 || pk_pwm_h !== 1'b0) sat_bad++;
    end
    check("sat_low_steady", 32'(sat_bad), 0);
    check("peak_same_cycle_old", 32'(pk_cmp), 0);
    check("valley_wait_cmp", 32'(cmp_active), 0);

    // Valley load of 400
    tick(); l0 = cyc;
    check("load400_valley", 32'(cmp_active), 400);
    check("load400_peak_inst", 32'(pk_cmp), 400);
    run_to(l0 + 1);
    check("l_still_on", 32'(pwm_l), 1);
    run_to(l0 + 2);
    check("l_falls", 32'({pwm_h, pwm_l}), 0);
    run_to(l0 + 41);
    check("h_dead_39", 32'(pwm_h), 0);
    run_to(l0 + 42);
    check("h_rises_40", 32'(pwm_h), 1);
    run_to(l0 + 400);
    check("h_before_cross", 32'(pwm_h), 1);
    run_to(l0 + 401);
    check("h_falls_cross", 32'({pwm_h, pwm_l}), 0);
    run_to(l0 + 440);
    check("l_dead_39", 32'(pwm_l), 0);
    run_to(l0 + 441);
    check("l_rises_40", 32'(pwm_l), 1);

    // Shadow write mid-period
    run_to(l0 + 699);
    duty_in = 16'd700; duty_wr = 1'b1;
    tick();
    duty_wr = 1'b0;
    run_to(l0 + 999);
    check("peak_inst_before_peak", 32'(pk_cmp), 400);
    run_to(l0 + 1000);
    check("peak_inst_at_peak", 32'(pk_cmp), 700);
    check("valley_inst_holds", 32'(cmp_active), 400);
    run_to(l0 + 1999);
    check("valley_holds_to_end", 32'(cmp_active), 400);

    // Same-cycle write and valley load: old shadow transferred
    duty_in = 16'd2000; duty_wr = 1'b1;
    tick();
    duty_wr = 1'b0;
    check("valley_same_cycle_old", 32'(cmp_active), 700);
    check("peak_inst_valley_old", 32'(pk_cmp), 700);
    run_to(l0 + 3000);
    check("peak_inst_2000", 32'(pk_cmp), 2000);

    // Saturation high: high side steady across and after the update to 2000
    run_to(l0 + 3400);
    while (cyc < l0 + 3999) begin
      tick();
      if (pwm_h !== 1'b1 || pwm_l !== 1'b0) sat_bad++;
    end
    check("cmp_700_before", 32'(cmp_active), 700);
    tick();
    if (pwm_h !== 1'b1 || pwm_l !== 1'b0) sat_bad++;
    check("cmp_2000_valley", 32'(cmp_active), 2000);
    while (cyc < l0 + 6000) begin
      tick();
      if (pwm_h !== 1'b1 || pwm_l !== 1'b0) sat_bad++;
    end
    check("sat_high_steady", 32'(sat_bad), 0);

    // Glitch during dead time: raw 1->0 (G+1), ->1 (G+4), ->0 (G+8)
    tri_run = 1'b0; g0 = cyc;
    carrier = 16'd3000;
    run_to(g0 + 2);
    check("glitch_h_falls", 32'(pwm_h), 0);
    run_to(g0 + 3);
    carrier = 16'd100;
    run_to(g0 + 7);
    carrier = 16'd3000;
    while (cyc < g0 + 48) begin
      tick();
      if (pwm_h || pwm_l) glitch_bad++;
    end
    check("glitch_gates_low", 32'(glitch_bad), 0);
    run_to(g0 + 49);
    check("glitch_l_after_last", 32'(pwm_l), 1);

    // Trip in H_ON
    run_to(g0 + 59);
    carrier = 16'd100;
    run_to(g0 + 101);
    check("trip_pre_h_on", 32'(pwm_h), 1);
    run_to(g0 + 109);
    fault_in = 1'b1;
    tick();
    check("trip_set", 32'(trip), 1);
    check("trip_h_off", 32'(pwm_h), 0);
    tick();
    trip_clr = 1'b1;
    tick();
    trip_clr = 1'b0; fault_in = 1'b0;
    check("trip_clr_ignored", 32'(trip), 1);
    run_to(g0 + 114);
    trip_clr = 1'b1;
    tick();
    trip_clr = 1'b0;
    check("trip_cleared", 32'(trip), 0);
    run_to(g0 + 155);
    check("trip_dead_h", 32'(pwm_h), 0);
    run_to(g0 + 156);
    check("trip_h_resumes", 32'(pwm_h), 1);

    // Enable 1->0->1
    run_to(g0 + 159);
    enable = 1'b0;
    tick();
    check("dis_gates_low", 32'({pwm_h, pwm_l}), 0);
    tick(); tick();
    enable = 1'b1;
    run_to(g0 + 202);
    check("reen_dead_h", 32'(pwm_h), 0);
    run_to(g0 + 203);
    check("reen_h_on", 32'(pwm_h), 1);

    // Asynchronous reset in L_ON
    run_to(g0 + 209);
    carrier = 16'd3000;
    run_to(g0 + 251);
    check("pre_rst_l_on", 32'(pwm_l), 1);
    #5 reset = 1'b1;
    #1;
    check("async_rst_l", 32'(pwm_l), 0);
    check("async_rst_cmp", 32'(cmp_active), 0);
    tick();
    reset = 1'b0; r0 = cyc;
    run_to(r0 + 40);
    check("post_rst_dead", 32'(pwm_l), 0);
    run_to(r0 + 41);
    check("post_rst_l_on", 32'(pwm_l), 1);
    check("post_rst_cmp0", 32'(cmp_active), 0);

    check("no_overlap", 32'(overlap), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_gen.md
Name: pwm_deadtime_gen

Overview:
- Downstream consumer of the triangle carrier stage. Takes the 16-bit carrier value and its direction, compares it with a shadowed duty value, and drives one inverter leg as a complementary high/low gate pair with programmable dead time.
- Also provides an enable gate and a latched fault trip.
- One instance per phase leg; gate outputs go to the IO pads.

Parameters:
- DEAD_CYCLES, 40, dead-time length in clk_20M cycles (2 us at 20 MHz); legal range 1..65535.
- UPDATE_AT_PEAK, 0, 1 = shadow-to-active compare transfer also occurs at the carrier peak; 0 = transfer at the valley only.

Ports:
- clk_20M  in  1  system clock, 20 MHz
- reset  in  1  asynchronous, active-high reset
- carrier  in  16  triangle carrier value from the carrier stage
- carrier_dir  in  1  carrier direction from the carrier stage: 1 = counting down, 0 = counting up
- duty_in  in  16  new compare value
- duty_wr  in  1  one-cycle strobe that captures duty_in into the shadow register
- enable  in  1  leg enable; 0 forces both gates low
- fault_in  in  1  synchronous hardware fault request, active high
- trip_clr  in  1  one-cycle strobe that clears the trip latch
- pwm_h  out  1  high-side gate, active high
- pwm_l  out  1  low-side gate, active high
- trip  out  1  trip latch status
- cmp_active  out  16  compare value currently in use (for debug/readback)

Behaviour:
- Reset (asynchronous, active-high): all registers cleared.
  - pwm_h=0, pwm_l=0, trip=0, cmp_active=0, shadow=0.
  - FSM in OFF; dead counter=0.
- Shadow register:
  - duty_wr=1 loads duty_in into shadow on the same edge.
  - Load event: carrier==0, or (UPDATE_AT_PEAK=1 and carrier_dir rising edge, i.e. peak reached). On a load event, cmp_active<=shadow.
  - duty_wr and a load event in the same cycle: cmp_active takes the old shadow; the new value waits for the next event.
- Compare:
  - raw_q <= (carrier < cmp_active), registered, 1 cycle latency.
  - cmp_active=0 gives raw_q constant 0 (low side held on).
  - cmp_active greater than the carrier peak gives raw_q constant 1.
  - Unsigned 16-bit compare, no wrap.
- FSM states: OFF, DEAD_TO_H, DEAD_TO_L, H_ON, L_ON.
  - Outputs are registered and change on the same edge as the state.
  - OFF: both low. Leaves when enable=1 and trip=0, going to DEAD_TO_H if raw_q=1, else DEAD_TO_L; counter<=DEAD_CYCLES.
  - DEAD_TO_x: both low; counter decrements each cycle. Counter reaching 1 with raw_q still matching x → x_ON on the next edge.
  - If raw_q flips during dead time → switch to the opposite DEAD state and reload the counter with DEAD_CYCLES.
  - H_ON: pwm_h=1. raw_q=0 → DEAD_TO_L, counter<=DEAD_CYCLES, pwm_h<=0 on that edge.
  - L_ON: symmetric to H_ON.
  - Guarantee: pwm_h and pwm_l are never 1 together. Both are low for exactly DEAD_CYCLES cycles at every transition.
- Latency: carrier crossing sampled at edge E0 → raw_q at E1 → old gate low at E2 → new gate high at E2+DEAD_CYCLES.
- Enable:
  - enable=0 in any state → OFF at the next edge, both gates low.
  - Re-enable always passes through a full dead time.
- Trip:
  - fault_in=1 sampled at an edge → trip<=1 and FSM<=OFF on that same edge, so gates are low one cycle after fault assertion.
  - Trip has priority over enable and over the compare.
  - trip_clr clears trip only if fault_in=0 in that cycle; otherwise ignored.
  - After clear, FSM leaves OFF through a full dead time.
- Reset mid-operation: gates drop asynchronously. After release, the block starts from OFF with cmp_active=0 until the first load event.

Test Plan:
- Dead time, high to low: DEAD_CYCLES=40, triangle model 0..1000..0, duty_wr=400 before the valley. Required:
  - cmp_active=400 after carrier==0.
  - pwm_h high while carrier<400.
  - At the crossing, pwm_h falls 2 cycles later; pwm_l rises exactly 40 cycles after that.
  - Symmetric timing on the low-to-high transition.
- Shadow timing: duty_wr=700 mid-period. Required:
  - cmp_active stays 400 until the next carrier==0.
  - With UPDATE_AT_PEAK=1, cmp_active instead updates at the next peak.
  - Same-cycle duty_wr and load event → old shadow transferred.
- Saturation: cmp_active=0 → pwm_l constant 1, pwm_h 0. cmp_active=2000 with peak 1000 → pwm_h constant 1. No dead-time gaps in either case.
- Glitch in dead time: force raw toggling 1→0→1 within 10 cycles. Required:
  - Counter reloads on each flip.
  - Both gates stay low until 40 cycles after the last flip.
  - pwm_h and pwm_l never both 1.
- Trip: fault_in pulse in H_ON. Required:
  - trip=1 and pwm_h=0 one cycle later.
  - trip_clr while fault_in=1 is ignored.
  - trip_clr after fault_in=0 → trip=0; the first gate asserts 40 cycles later.
- Reset and enable:
  - Assert reset in L_ON → pwm_l=0 immediately (asynchronous).
  - enable 1→0→1 → both gates low, then 40-cycle dead time before any gate asserts.
